spi_slave_ctrl: RTL
===================

Name: spi_slave_ctrl

Overview:
- Upstream SPI slave controller that feeds the FPGA register file.
- Oversamples the external SPI pins (SCLK, CSB, SDIO split into SDI/SDO) on the master clock and decodes ADI-style 16-bit instruction frames.
- Drives the register file's enable, write-enable, address and data inputs, and serialises its read data back out on SDO.
- Register-file side is fully synchronous to I_clk. The enable is held for the whole CSB-low window, so the falling enable edge marks end of transaction for downstream latching.

Parameters:
- ADDR_SIZE, 8: width of O_addr. Instruction address bits above this width must be zero for an access to be valid.
- DATA_SIZE, 8: data byte width. Fixed at 8 for the ADI frame format.
- SYNC_STAGES, 2: flip-flop stages in each input synchroniser (minimum 2).

Ports:
- I_clk  in  1  master clock; must run at ≥ 8× SCLK.
- I_reset  in  1  asynchronous, active-high reset.
- I_sclk  in  1  SPI clock, asynchronous; SPI mode 0 (idle low).
- I_csb  in  1  SPI chip select, active low, asynchronous.
- I_sdi  in  1  SPI serial data in.
- O_sdo  out  1  SPI serial data out.
- O_sdo_oe  out  1  SDO output enable; drives the pin tristate.
- O_enable  out  1  register-file access enable.
- O_wen  out  1  register write strobe; one I_clk wide.
- O_addr  out  ADDR_SIZE  register address.
- O_din  out  DATA_SIZE  write data to register file.
- I_dout  in  DATA_SIZE  read data from register file; combinational from O_addr.

Behaviour:
- Reset (async, active-high):
  - All outputs low: O_sdo=0, O_sdo_oe=0, O_enable=0, O_wen=0, O_addr=0, O_din=0.
  - FSM=IDLE, bit counter=0, synchronisers cleared with CSB forced high.
  - Reset mid-transaction aborts it; no write is issued. The transaction resumes only after a new CSB falling edge.
- Input sampling:
  - SCLK, CSB and SDI each pass through SYNC_STAGES flops.
  - Rise and fall edges of SCLK are detected from the last two synchronised samples (one-cycle pulses).
- O_enable:
  - Registered. Goes high the cycle after synchronised CSB is seen low; goes low the cycle after it is seen high.
  - Must be glitch-free.
- Instruction format (16 bits, MSB first):
  - bit15 = R/W (1 = read).
  - bits14:13 = W1:W0, byte count minus 1.
  - bits12:0 = start address.
- FSM:
  - IDLE: wait for CSB low → INSTR.
  - INSTR: shift SDI on each SCLK rise; after the 16th rise, latch the fields, set O_addr = addr[ADDR_SIZE-1:0], set remaining = W+1 → DATA.
  - DATA: 8 SCLK rises per byte. Write: after the 8th rise, O_din ← shift register; next cycle O_wen pulses for 1 cycle. Read: see below. After each byte, O_addr decrements by 1 (wrap 0x00 → 0xFF) and remaining decrements; remaining = 0 → DONE.
  - DONE: ignore SCLK/SDI until CSB high.
  - CSB high in any state → IDLE the next cycle. A partial instruction or byte is discarded and no O_wen is issued.
- Read path:
  - One cycle after O_addr becomes valid, I_dout is loaded into the SDO shift register.
  - O_sdo_oe rises on the SCLK fall following the 16th instruction rise.
  - The MSB is driven on that fall; each following SCLK fall shifts the next bit.
  - The next byte is reloaded from the decremented address after its 8th rise.
  - O_sdo_oe = 1 only during read data bytes. It drops on CSB high or on entry to DONE.
- Address range check:
  - If addr[12:ADDR_SIZE] ≠ 0: writes are suppressed (no O_wen) and reads shift out 0x00.
  - The check is re-evaluated after each decrement.
- Simultaneous events: CSB high has priority over an SCLK edge in the same cycle.

Optional Feature:
- Macro: SPI_STREAM_EN.
- Defined: W1:W0 = 11 selects streaming. Bytes continue indefinitely with address decrement until CSB high, and DONE is never entered.
- Undefined: W1:W0 = 11 means exactly 4 bytes, then DONE.

Test Plan:
- Write 1 byte: instr 0x0003, data 0x5A → exactly one O_wen with O_addr=0x03, O_din=0x5A. O_enable low within 1+SYNC_STAGES cycles of CSB high.
- Read: instr 0x8001 with I_dout=0x01 at addr 0x01 → SDO shows 00000001 over 8 SCLK falls, O_sdo_oe high only for those bits, no O_wen.
- Multi-byte write: instr 0x2003 (W=01), data 0x11, 0x22, then 8 extra SCLKs → O_wen at addr 0x03 with 0x11, then at 0x02 with 0x22; extra clocks produce no write.
- Abort: CSB high after 4 data bits of a write → no O_wen, FSM IDLE. A following 0x0003/0x77 write succeeds.
- Out of range: instr 0x0103, data 0xFF → no O_wen. Read 0x8103 → SDO shifts 0x00.
- Mode W=11, 6 data bytes: with SPI_STREAM_EN → 6 writes, addresses 0x05 down to 0x00. Without it → 4 writes, then ignored. Also assert I_reset mid-instruction → all outputs 0 immediately.

Source files
------------

// File: rtl/spi_slave_ctrl.sv
// rtl/spi_slave_ctrl.sv - ADI-style SPI slave front end for the FPGA register file
// Optional SPI_STREAM_EN: W1:W0 = 11 streams bytes until CSB high instead of stopping after 4.
module spi_slave_ctrl #(
  parameter int ADDR_SIZE   = 8,
  parameter int DATA_SIZE   = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 I_clk,
  input  logic                 I_reset,
  input  logic                 I_sclk,
  input  logic                 I_csb,
  input  logic                 I_sdi,
  output logic                 O_sdo,
  output logic                 O_sdo_oe,
  output logic                 O_enable,
  output logic                 O_wen,
  output logic [ADDR_SIZE-1:0] O_addr,
  output logic [DATA_SIZE-1:0] O_din,
  input  logic [DATA_SIZE-1:0] I_dout
);

`ifdef SPI_STREAM_EN
  localparam logic STREAM_EN = 1'b1;
`else
  localparam logic STREAM_EN = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, INSTR, DATA, DONE} state_t;

  logic [SYNC_STAGES-1:0] sclk_sync_q, csb_sync_q, sdi_sync_q;
  logic                   sclk_last_q;
  logic                   sclk_s, csb_s, sdi_s, sclk_rise, sclk_fall;

  state_t                 state_q, state_d;
  logic [3:0]             bit_cnt_q, bit_cnt_d;
  logic [14:0]            shift_q, shift_d;
  logic                   rw_q, rw_d;
  logic [2:0]             rem_q, rem_d;
  logic [12:0]            addr_q, addr_d;
  logic [DATA_SIZE-1:0]   din_q, din_d;
  logic                   wen_q, wen_d;
  logic                   byte_done_q, byte_done_d;
  logic                   load_q, load_d;
  logic [DATA_SIZE-1:0]   sdo_shift_q, sdo_shift_d;
  logic                   sdo_q, sdo_d;
  logic                   sdo_oe_q, sdo_oe_d;
  logic                   enable_q;
  logic [15:0]            instr_word;
  logic                   oor;

  always_ff @(posedge I_clk or posedge I_reset) begin
    if (I_reset) begin
      sclk_sync_q <= '0;
      csb_sync_q  <= '1;
      sdi_sync_q  <= '0;
      sclk_last_q <= 1'b0;
    end else begin
      sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], I_sclk};
      csb_sync_q  <= {csb_sync_q[SYNC_STAGES-2:0], I_csb};
      sdi_sync_q  <= {sdi_sync_q[SYNC_STAGES-2:0], I_sdi};
      sclk_last_q <= sclk_s;
    end
  end

  assign sclk_s     = sclk_sync_q[SYNC_STAGES-1];
  assign csb_s      = csb_sync_q[SYNC_STAGES-1];
  assign sdi_s      = sdi_sync_q[SYNC_STAGES-1];
  assign sclk_rise  = sclk_s & ~sclk_last_q;
  assign sclk_fall  = ~sclk_s & sclk_last_q;
  assign instr_word = {shift_q, sdi_s};
  // The full 13-bit address is kept so the range check follows every decrement.
  assign oor        = |(addr_q >> ADDR_SIZE);

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    rw_d        = rw_q;
    rem_d       = rem_q;
    addr_d      = addr_q;
    din_d       = din_q;
    wen_d       = 1'b0;
    byte_done_d = 1'b0;
    load_d      = 1'b0;
    sdo_shift_d = sdo_shift_q;
    sdo_d       = sdo_q;
    sdo_oe_d    = sdo_oe_q;

    case (state_q)
      IDLE: begin
        if (!csb_s) begin
          state_d   = INSTR;
          bit_cnt_d = 4'd0;
        end
      end
      INSTR: begin
        if (sclk_rise) begin
          shift_d   = instr_word[14:0];
          bit_cnt_d = bit_cnt_q + 4'd1;
          if (bit_cnt_q == 4'd15) begin
            rw_d      = instr_word[15];
            // rem = 0 marks an endless stream
            rem_d     = (STREAM_EN && (&instr_word[14:13])) ? 3'd0
                                                            : {1'b0, instr_word[14:13]} + 3'd1;
            addr_d    = instr_word[12:0];
            bit_cnt_d = 4'd0;
            load_d    = 1'b1;
            state_d   = DATA;
          end
        end
      end
      DATA: begin
        if (sclk_rise) begin
          shift_d   = instr_word[14:0];
          bit_cnt_d = bit_cnt_q + 4'd1;
          if (bit_cnt_q == 4'(DATA_SIZE-1)) begin
            bit_cnt_d   = 4'd0;
            byte_done_d = 1'b1;
            if (!rw_q) begin
              din_d = instr_word[DATA_SIZE-1:0];
              wen_d = ~oor;
            end
          end
        end
        if (sclk_fall && rw_q) begin
          sdo_oe_d    = 1'b1;
          sdo_d       = sdo_shift_q[DATA_SIZE-1];
          sdo_shift_d = {sdo_shift_q[DATA_SIZE-2:0], 1'b0};
        end
        // Address steps only after the write strobe has been seen with the old address.
        if (byte_done_q) begin
          addr_d = addr_q - 13'd1;
          load_d = 1'b1;
          if (rem_q != 3'd0) rem_d = rem_q - 3'd1;
          if (rem_q == 3'd1) begin
            state_d  = DONE;
            sdo_oe_d = 1'b0;
          end
        end
      end
      DONE: sdo_oe_d = 1'b0;
    endcase

    if (load_q) sdo_shift_d = oor ? '0 : I_dout;

    if (csb_s) begin
      state_d     = IDLE;
      sdo_oe_d    = 1'b0;
      sdo_d       = 1'b0;
      wen_d       = 1'b0;
      byte_done_d = 1'b0;
      load_d      = 1'b0;
    end
  end

  always_ff @(posedge I_clk or posedge I_reset) begin
    if (I_reset) begin
      state_q     <= IDLE;
      bit_cnt_q   <= 4'd0;
      shift_q     <= '0;
      rw_q        <= 1'b0;
      rem_q       <= 3'd0;
      addr_q      <= '0;
      din_q       <= '0;
      wen_q       <= 1'b0;
      byte_done_q <= 1'b0;
      load_q      <= 1'b0;
      sdo_shift_q <= '0;
      sdo_q       <= 1'b0;
      sdo_oe_q    <= 1'b0;
      enable_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      rw_q        <= rw_d;
      rem_q       <= rem_d;
      addr_q      <= addr_d;
      din_q       <= din_d;
      wen_q       <= wen_d;
      byte_done_q <= byte_done_d;
      load_q      <= load_d;
      sdo_shift_q <= sdo_shift_d;
      sdo_q       <= sdo_d;
      sdo_oe_q    <= sdo_oe_d;
      enable_q    <= ~csb_s;
    end
  end

  assign O_sdo    = sdo_q;
  assign O_sdo_oe = sdo_oe_q;
  assign O_enable = enable_q;
  assign O_wen    = wen_q;
  assign O_addr   = addr_q[ADDR_SIZE-1:0];
  assign O_din    = din_q;

endmodule
